branch_predictor_btb: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage MIPS pipeline: a direct-mapped branch target buffer with saturating direction counters.
- Queried combinationally by IF with the current PC; trained from EX when a branch or jump resolves.
- Lets IF redirect fetch speculatively, replacing the static predict-not-taken with EX-stage flush.
- Computes the mispredict flag and the corrected PC for the pipeline, and keeps hit and mispredict statistics alongside the existing cycle, branch and bubble counters.

---
 rtl/branch_predictor_btb.sv | 108 ++++++++++
 tb/tb_branch_predictor_btb.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_btb.sv
// rtl/branch_predictor_btb.sv - direct-mapped BTB with saturating direction counters
// Combinational IF lookup, EX-stage training, mispredict/correct-PC generation and hit/mispredict stats.
module branch_predictor_btb #(
    parameter int PC_BITS    = 32,
    parameter int ENTRY_BITS = 4,
    parameter int CNT_BITS   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_all,
    input  logic               lookup_valid,
    input  logic [PC_BITS-1:0] if_pc,
    output logic               pred_hit,
    output logic               pred_taken,
    output logic [PC_BITS-1:0] pred_target,
    input  logic               upd_valid,
    input  logic               upd_uncond,
    input  logic [PC_BITS-1:0] upd_pc,
    input  logic               upd_taken,
    input  logic [PC_BITS-1:0] upd_target,
    input  logic               upd_pred_taken,
    input  logic [PC_BITS-1:0] upd_pred_target,
    output logic               mispredict,
    output logic [PC_BITS-1:0] correct_pc,
    output logic [31:0]        hit_num,
    output logic [31:0]        mispredict_num
);
    localparam int DEPTH = 1 << ENTRY_BITS;
    localparam int TAG_W = PC_BITS - ENTRY_BITS - 2;
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

    logic [DEPTH-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q    [DEPTH];
    logic [PC_BITS-1:0]  target_q [DEPTH];
    logic [CNT_BITS-1:0] cnt_q    [DEPTH];

    logic [ENTRY_BITS-1:0] lk_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic [ENTRY_BITS-1:0] up_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_hit;
    logic                  up_write_entry;
    logic                  up_write_target;
    logic [CNT_BITS-1:0]   up_cnt;

    // Word-aligned PCs: the two low bits never select or tag an entry.
    logic unused_pc_bits;
    assign unused_pc_bits = &{1'b0, if_pc[1:0], upd_pc[1:0]};

    assign lk_idx      = if_pc[ENTRY_BITS+1:2];
    assign lk_tag      = if_pc[PC_BITS-1:ENTRY_BITS+2];
    assign pred_hit    = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    assign pred_taken  = pred_hit && cnt_q[lk_idx][CNT_BITS-1];
    assign pred_target = pred_taken ? target_q[lk_idx] : if_pc + PC_BITS'(4);

    assign mispredict = upd_valid && ((upd_pred_taken != upd_taken) ||
                                      (upd_taken && (upd_pred_target != upd_target)));
    assign correct_pc = upd_taken ? upd_target : upd_pc + PC_BITS'(4);

    assign up_idx = upd_pc[ENTRY_BITS+1:2];
    assign up_tag = upd_pc[PC_BITS-1:ENTRY_BITS+2];
    assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

    // A not-taken miss leaves the slot alone; hits always retrain the counter.
    assign up_write_entry  = up_hit || upd_taken;
    assign up_write_target = upd_taken || (up_hit && upd_uncond);

    always_comb begin
        up_cnt = cnt_q[up_idx];
        if (up_hit) begin
            if (upd_uncond) begin
                up_cnt = CNT_MAX;
            end else if (upd_taken) begin
                if (cnt_q[up_idx] != CNT_MAX) up_cnt = cnt_q[up_idx] + CNT_BITS'(1);
            end else begin
                if (cnt_q[up_idx] != '0) up_cnt = cnt_q[up_idx] - CNT_BITS'(1);
            end
        end else begin
            up_cnt = upd_uncond ? CNT_MAX : CNT_WT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q        <= '0;
            hit_num        <= '0;
            mispredict_num <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                tag_q[i]    <= '0;
                target_q[i] <= '0;
                cnt_q[i]    <= CNT_WNT;
            end
        end else begin
            if (flush_all) begin
                valid_q <= '0;
            end else if (upd_valid && up_write_entry) begin
                valid_q[up_idx] <= 1'b1;
                tag_q[up_idx]   <= up_tag;
                cnt_q[up_idx]   <= up_cnt;
                if (up_write_target) target_q[up_idx] <= upd_target;
            end
            if (lookup_valid && pred_hit) hit_num <= hit_num + 32'd1;
            if (mispredict) mispredict_num <= mispredict_num + 32'd1;
        end
    end
endmodule

// File: tb/tb_branch_predictor_btb.sv
// tb/tb_branch_predictor_btb.sv - scoreboard bench for branch_predictor_btb
// Stimulus queues hand-computed expectations; a negedge monitor pops and compares them.
module tb_branch_predictor_btb;
    logic        clk = 1'b0;
    logic        rst, flush_all, lookup_valid;
    logic [31:0] if_pc;
    logic        pred_hit, pred_taken;
    logic [31:0] pred_target;
    logic        upd_valid, upd_uncond, upd_taken, upd_pred_taken;
    logic [31:0] upd_pc, upd_target, upd_pred_target;
    logic        mispredict;
    logic [31:0] correct_pc, hit_num, mispredict_num;

    branch_predictor_btb dut (
        .clk(clk), .rst(rst), .flush_all(flush_all), .lookup_valid(lookup_valid),
        .if_pc(if_pc), .pred_hit(pred_hit), .pred_taken(pred_taken),
        .pred_target(pred_target), .upd_valid(upd_valid), .upd_uncond(upd_uncond),
        .upd_pc(upd_pc), .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .mispredict(mispredict), .correct_pc(correct_pc), .hit_num(hit_num),
        .mispredict_num(mispredict_num)
    );

    always #5 clk = ~clk;

    typedef enum int {F_HIT, F_TAKEN, F_TGT, F_MIS, F_CPC, F_HNUM, F_MNUM} field_t;
    typedef struct {
        field_t      field;
        logic [31:0] value;
        string       name;
    } exp_t;

    exp_t q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;
    int   cyc_id    = 0;

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t        e;
            logic [31:0] got;
            e = q.pop_front();
            case (e.field)
                F_HIT:   got = {31'd0, pred_hit};
                F_TAKEN: got = {31'd0, pred_taken};
                F_TGT:   got = pred_target;
                F_MIS:   got = {31'd0, mispredict};
                F_CPC:   got = correct_pc;
                F_HNUM:  got = hit_num;
                default: got = mispredict_num;
            endcase
            total_cnt++;
            if (got === e.value) pass_cnt++;
            else $display("FAIL %s: got %h expected %h", e.name, got, e.value);
        end
    end

    task automatic push(field_t f, logic [31:0] v, string n);
        exp_t e;
        e.field = f;
        e.value = v;
        e.name  = $sformatf("c%0d_%s", cyc_id, n);
        q.push_back(e);
    endtask

    task automatic chk_lk(logic h, logic t, logic [31:0] tgt);
        push(F_HIT, {31'd0, h}, "pred_hit");
        push(F_TAKEN, {31'd0, t}, "pred_taken");
        push(F_TGT, tgt, "pred_target");
    endtask

    task automatic chk_up(logic m, logic [31:0] cpc);
        push(F_MIS, {31'd0, m}, "mispredict");
        push(F_CPC, cpc, "correct_pc");
    endtask

    task automatic chk_st(logic [31:0] h, logic [31:0] m);
        push(F_HNUM, h, "hit_num");
        push(F_MNUM, m, "mispredict_num");
    endtask

    task automatic look(logic lv, logic [31:0] pc);
        lookup_valid = lv;
        if_pc        = pc;
    endtask

    task automatic upd(logic unc, logic [31:0] pc, logic tk, logic [31:0] tgt,
                       logic ptk, logic [31:0] ptgt);
        upd_valid       = 1'b1;
        upd_uncond      = unc;
        upd_pc          = pc;
        upd_taken       = tk;
        upd_target      = tgt;
        upd_pred_taken  = ptk;
        upd_pred_target = ptgt;
    endtask

    task automatic no_upd();
        upd_valid = 1'b0;
        push(F_MIS, 32'd0, "mispredict_idle");
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc_id++;
        flush_all = 1'b0;
        rst       = 1'b0;
        upd_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush_all = 1'b0; lookup_valid = 1'b0; if_pc = '0;
        upd_valid = 1'b0; upd_uncond = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_target = '0;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        // reset state
        look(1, 32'h40); no_upd(); chk_lk(0, 0, 32'h44); chk_st(0, 0); step();
        // allocate 0x40 -> 0x100, not visible same cycle
        look(1, 32'h40); upd(0, 32'h40, 1, 32'h100, 0, 32'h44);
        chk_up(1, 32'h100); chk_lk(0, 0, 32'h44); chk_st(0, 0); step();
        look(1, 32'h40); no_upd(); chk_lk(1, 1, 32'h100); chk_st(0, 1); step();
        // not-taken training 10 -> 01 -> 00 -> 00
        look(1, 32'h40); upd(0, 32'h40, 0, 32'h100, 1, 32'h100);
        chk_up(1, 32'h44); chk_lk(1, 1, 32'h100); chk_st(1, 1); step();
        look(1, 32'h40); upd(0, 32'h40, 0, 32'h100, 0, 32'h44);
        chk_up(0, 32'h44); chk_lk(1, 0, 32'h44); chk_st(2, 2); step();
        look(1, 32'h40); upd(0, 32'h40, 0, 32'h100, 0, 32'h44);
        chk_up(0, 32'h44); chk_lk(1, 0, 32'h44); chk_st(3, 2); step();
        // taken training 00 -> 01 -> 10 -> 11 -> 11
        look(1, 32'h40); upd(0, 32'h40, 1, 32'h100, 0, 32'h44);
        chk_up(1, 32'h100); chk_lk(1, 0, 32'h44); chk_st(4, 2); step();
        look(1, 32'h40); upd(0, 32'h40, 1, 32'h100, 0, 32'h44);
        chk_up(1, 32'h100); chk_lk(1, 0, 32'h44); chk_st(5, 3); step();
        look(1, 32'h40); upd(0, 32'h40, 1, 32'h100, 1, 32'h100);
        chk_up(0, 32'h100); chk_lk(1, 1, 32'h100); chk_st(6, 4); step();
        look(1, 32'h40); upd(0, 32'h40, 1, 32'h104, 1, 32'h100);
        chk_up(1, 32'h104); chk_lk(1, 1, 32'h100); chk_st(7, 4); step();
        // lookup_valid low: no hit counted
        look(0, 32'h40); no_upd(); chk_lk(1, 1, 32'h104); chk_st(8, 5); step();
        // one not-taken from saturated 11 stays taken
        look(1, 32'h40); upd(0, 32'h40, 0, 32'h104, 1, 32'h104);
        chk_up(1, 32'h44); chk_lk(1, 1, 32'h104); chk_st(8, 5); step();
        look(1, 32'h40); no_upd(); chk_lk(1, 1, 32'h104); chk_st(9, 6); step();
        // aliasing: 0x80 shares index 0 with 0x40
        look(1, 32'h80); upd(0, 32'h80, 1, 32'h300, 0, 32'h84);
        chk_up(1, 32'h300); chk_lk(0, 0, 32'h84); chk_st(10, 6); step();
        look(1, 32'h40); no_upd(); chk_lk(0, 0, 32'h44); chk_st(10, 7); step();
        look(1, 32'h80); no_upd(); chk_lk(1, 1, 32'h300); chk_st(10, 7); step();
        // unconditional allocate starts strongly taken
        look(1, 32'h80); upd(1, 32'h84, 1, 32'h1000, 0, 32'h88);
        chk_up(1, 32'h1000); chk_lk(1, 1, 32'h300); chk_st(11, 7); step();
        look(1, 32'h84); upd(0, 32'h84, 0, 32'h1000, 1, 32'h1000);
        chk_up(1, 32'h88); chk_lk(1, 1, 32'h1000); chk_st(12, 8); step();
        look(1, 32'h84); no_upd(); chk_lk(1, 1, 32'h1000); chk_st(13, 9); step();
        // flush beats a same-edge allocate; mispredict still counted
        flush_all = 1'b1;
        look(1, 32'h84); upd(0, 32'h200, 1, 32'h400, 0, 32'h204);
        chk_up(1, 32'h400); chk_lk(1, 1, 32'h1000); chk_st(14, 9); step();
        look(1, 32'h200); no_upd(); chk_lk(0, 0, 32'h204); chk_st(15, 10); step();
        look(1, 32'h84); no_upd(); chk_lk(0, 0, 32'h88); chk_st(15, 10); step();
        // pc+4 wraps; allocate 0x40 ahead of mid-run reset
        look(1, 32'hFFFF_FFFC); upd(0, 32'h40, 1, 32'h500, 0, 32'h44);
        chk_up(1, 32'h500); chk_lk(0, 0, 32'h0); chk_st(15, 10); step();
        rst = 1'b1;
        look(1, 32'h40); no_upd(); chk_lk(1, 1, 32'h500); chk_st(15, 11); step();
        look(1, 32'h40); no_upd(); chk_lk(0, 0, 32'h44); chk_st(0, 0);

        for (int i = 0; i < 5 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            total_cnt++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
